// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline control for the five-stage Y86 core.
// Decides per cycle which pipeline registers stall, take a bubble or load,
// and sequences the M-stage data-memory handshake with wait-state stalls
// and a timeout that halts the core.
// Optional feature macro: PIPE_CTRL_PERF_EN builds the stall/bubble perf
// counters; without it stall_cnt_o and bubble_cnt_o are tied to zero.
// dbg_state_o / dbg_wait_cnt_o expose the FSM for observation only.
`ifndef NIBBLE
`define NIBBLE [3:0]
`endif

module pipe_ctrl #(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic `NIBBLE     D_icode_i,
  input  logic `NIBBLE     d_srcA_i,
  input  logic `NIBBLE     d_srcB_i,
  input  logic `NIBBLE     E_icode_i,
  input  logic `NIBBLE     E_dstM_i,
  input  logic             e_Cnd_i,
  input  logic `NIBBLE     M_icode_i,
  input  logic `NIBBLE     M_stat_i,
  input  logic `NIBBLE     m_stat_i,
  input  logic `NIBBLE     W_stat_i,
  input  logic             dmem_ack_i,
  output logic             dmem_req_o,
  output logic             F_stall_o,
  output logic             D_stall_o,
  output logic             E_stall_o,
  output logic             M_stall_o,
  output logic             W_stall_o,
  output logic             D_bubble_o,
  output logic             E_bubble_o,
  output logic             M_bubble_o,
  output logic             W_bubble_o,
  output logic             cc_en_o,
  output logic             halted_o,
  output logic             err_o,
  output logic [31:0]      stall_cnt_o,
  output logic [31:0]      bubble_cnt_o,
  output logic [1:0]       dbg_state_o,
  output logic [CNT_W-1:0] dbg_wait_cnt_o
);

  // Y86 instruction, register and status codes.
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;
  localparam logic [3:0] RNONE   = 4'hF;
  localparam logic [3:0] SAOK    = 4'h1;
  localparam logic [3:0] SADR    = 4'h2;
  localparam logic [3:0] SINS    = 4'h3;
  localparam logic [3:0] SHLT    = 4'h4;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALTED   = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic             err_nxt;
  logic             mem_op, mem_pending, mem_wait;
  logic             load_use, ret_hz, mispred, exc;

  // Memory handshake and hazard detection terms.
  always_comb begin
    mem_op      = M_icode_i inside {IRMMOVQ, IMRMOVQ, ICALL, IRET, IPUSHQ, IPOPQ};
    mem_pending = mem_op && (M_stat_i == SAOK) && (state != HALTED);
    mem_wait    = mem_pending && !dmem_ack_i;
    load_use    = (E_icode_i inside {IMRMOVQ, IPOPQ}) && (E_dstM_i != RNONE) &&
                  ((E_dstM_i == d_srcA_i) || (E_dstM_i == d_srcB_i));
    ret_hz      = (D_icode_i == IRET) || (E_icode_i == IRET) || (M_icode_i == IRET);
    mispred     = (E_icode_i == IJXX) && !e_Cnd_i;
    exc         = (m_stat_i inside {SADR, SINS, SHLT}) || (W_stat_i inside {SADR, SINS, SHLT});
  end

  // Pipeline register controls; reset forces everything quiet with CC enabled.
  always_comb begin
    dmem_req_o = 1'b0;
    F_stall_o  = 1'b0;
    D_stall_o  = 1'b0;
    E_stall_o  = 1'b0;
    M_stall_o  = 1'b0;
    W_stall_o  = 1'b0;
    D_bubble_o = 1'b0;
    E_bubble_o = 1'b0;
    M_bubble_o = 1'b0;
    W_bubble_o = 1'b0;
    cc_en_o    = 1'b1;
    halted_o   = 1'b0;
    if (!rst_i) begin
      dmem_req_o = mem_pending;
      if (state == HALTED) begin
        F_stall_o = 1'b1;
        D_stall_o = 1'b1;
        E_stall_o = 1'b1;
        M_stall_o = 1'b1;
        W_stall_o = 1'b1;
        cc_en_o   = 1'b0;
        halted_o  = 1'b1;
      end else if (mem_wait) begin
        // Waiting on memory freezes F..M and drains W; E is frozen so no CC update.
        F_stall_o  = 1'b1;
        D_stall_o  = 1'b1;
        E_stall_o  = 1'b1;
        M_stall_o  = 1'b1;
        W_bubble_o = 1'b1;
        cc_en_o    = 1'b0;
      end else begin
        F_stall_o  = load_use | ret_hz;
        D_stall_o  = load_use;
        D_bubble_o = mispred | (ret_hz & !load_use);
        E_bubble_o = mispred | load_use;
        M_bubble_o = exc;
        cc_en_o    = !exc;
        W_stall_o  = (W_stat_i != SAOK);
      end
    end
  end

  // Next-state logic; the timeout fires when the counter reaches WAIT_MAX.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    err_nxt      = err_o;
    case (state)
      RUN: begin
        if (W_stat_i != SAOK) begin
          state_nxt = HALTED;
        end else if (mem_wait) begin
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = CNT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (!mem_wait) begin
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
        end else begin
          wait_cnt_nxt = wait_cnt + CNT_W'(1);
          if (wait_cnt == CNT_W'(WAIT_MAX - 1)) begin
            state_nxt = HALTED;
            err_nxt   = 1'b1;
          end
        end
      end
      HALTED:  state_nxt = HALTED;
      default: state_nxt = RUN;
    endcase
  end

  // State, wait counter and sticky error register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= RUN;
      wait_cnt <= '0;
      err_o    <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      err_o    <= err_nxt;
    end
  end

  assign dbg_state_o    = state;
  assign dbg_wait_cnt_o = wait_cnt;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt, bubble_cnt;
  logic        hz_bubble;

  assign hz_bubble = (load_use | mispred) && !mem_wait && (state != HALTED);

  // Saturating performance counters for wait stalls and hazard bubbles.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (mem_wait && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
      if (hz_bubble && (bubble_cnt != '1)) bubble_cnt <= bubble_cnt + 32'd1;
    end
  end

  assign stall_cnt_o  = stall_cnt;
  assign bubble_cnt_o = bubble_cnt;
`else
  assign stall_cnt_o  = '0;
  assign bubble_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl: stimulus rows push expected control vectors into
// a scoreboard queue; each is popped and compared at the following negedge.
module tb_pipe_ctrl;

  localparam logic [3:0] INOP = 4'h1, IOPQ = 4'h6, IJXX = 4'h7, IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5, IRET = 4'h9, IPOPQ = 4'hB, RNONE = 4'hF;
  localparam logic [3:0] SAOK = 4'h1, SADR = 4'h2, SINS = 4'h3;
  localparam logic [1:0] S_RUN = 2'd0, S_WAIT = 2'd1, S_HALT = 2'd2;

  // Bit positions inside the observed control vector.
  localparam logic [12:0] B_REQ = 13'h1000, B_FS = 13'h0800, B_DS = 13'h0400;
  localparam logic [12:0] B_ES  = 13'h0200, B_MS = 13'h0100, B_WS = 13'h0080;
  localparam logic [12:0] B_DB  = 13'h0040, B_EB = 13'h0020, B_MB = 13'h0010;
  localparam logic [12:0] B_WB  = 13'h0008, B_CC = 13'h0004, B_HLT = 13'h0002;
  localparam logic [12:0] B_ERR = 13'h0001, FULL = 13'h1FFF;
  localparam logic [12:0] WMSK  = FULL & ~B_CC & ~B_WS;
  localparam logic [12:0] WAITV = B_REQ | B_FS | B_DS | B_ES | B_MS | B_WB;
  localparam logic [12:0] HALTV = B_FS | B_DS | B_ES | B_MS | B_WS | B_HLT;

`ifdef PIPE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct {
    logic [3:0]  d, sa, sb, e, dm;
    logic        cnd;
    logic [3:0]  m, ms, mso, ws;
    logic        ack;
    logic [12:0] exp, msk;
  } stim_t;

  logic        clk_i = 1'b0, rst_i;
  logic [3:0]  D_icode_i, d_srcA_i, d_srcB_i, E_icode_i, E_dstM_i;
  logic        e_Cnd_i, dmem_ack_i;
  logic [3:0]  M_icode_i, M_stat_i, m_stat_i, W_stat_i;
  logic        dmem_req_o, F_stall_o, D_stall_o, E_stall_o, M_stall_o, W_stall_o;
  logic        D_bubble_o, E_bubble_o, M_bubble_o, W_bubble_o;
  logic        cc_en_o, halted_o, err_o;
  logic [31:0] stall_cnt_o, bubble_cnt_o;
  logic [1:0]  dbg_state_o;
  logic [3:0]  dbg_wait_cnt_o;
  logic [12:0] obs;

  logic [12:0] exp_q[$];
  logic [12:0] msk_q[$];
  int n_checks = 0, n_fail = 0;
  int exp_stall = 0, exp_bub = 0;

  pipe_ctrl #(.WAIT_MAX(15), .CNT_W(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .D_icode_i(D_icode_i), .d_srcA_i(d_srcA_i), .d_srcB_i(d_srcB_i),
    .E_icode_i(E_icode_i), .E_dstM_i(E_dstM_i), .e_Cnd_i(e_Cnd_i),
    .M_icode_i(M_icode_i), .M_stat_i(M_stat_i), .m_stat_i(m_stat_i),
    .W_stat_i(W_stat_i), .dmem_ack_i(dmem_ack_i), .dmem_req_o(dmem_req_o),
    .F_stall_o(F_stall_o), .D_stall_o(D_stall_o), .E_stall_o(E_stall_o),
    .M_stall_o(M_stall_o), .W_stall_o(W_stall_o),
    .D_bubble_o(D_bubble_o), .E_bubble_o(E_bubble_o),
    .M_bubble_o(M_bubble_o), .W_bubble_o(W_bubble_o),
    .cc_en_o(cc_en_o), .halted_o(halted_o), .err_o(err_o),
    .stall_cnt_o(stall_cnt_o), .bubble_cnt_o(bubble_cnt_o),
    .dbg_state_o(dbg_state_o), .dbg_wait_cnt_o(dbg_wait_cnt_o)
  );

  assign obs = {dmem_req_o, F_stall_o, D_stall_o, E_stall_o, M_stall_o, W_stall_o,
                D_bubble_o, E_bubble_o, M_bubble_o, W_bubble_o, cc_en_o, halted_o, err_o};

  // Clock generation.
  always #5 clk_i = ~clk_i;

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic stim_t idle();
    stim_t t;
    t.d = INOP; t.sa = RNONE; t.sb = RNONE; t.e = INOP; t.dm = RNONE; t.cnd = 1'b1;
    t.m = INOP; t.ms = SAOK; t.mso = SAOK; t.ws = SAOK; t.ack = 1'b0;
    t.exp = B_CC; t.msk = FULL;
    return t;
  endfunction

  task automatic apply(input stim_t t);
    D_icode_i = t.d; d_srcA_i = t.sa; d_srcB_i = t.sb; E_icode_i = t.e; E_dstM_i = t.dm;
    e_Cnd_i = t.cnd; M_icode_i = t.m; M_stat_i = t.ms; m_stat_i = t.mso;
    W_stat_i = t.ws; dmem_ack_i = t.ack;
  endtask

  // Drive one row and queue its expectation; E_bubble marks a hazard bubble
  // and W_bubble marks a memory-wait cycle, which is what the counters count.
  task automatic drive(input stim_t t);
    apply(t);
    exp_q.push_back(t.exp & t.msk);
    msk_q.push_back(t.msk);
    if ((t.exp & B_EB) != 13'h0) exp_bub++;
    if ((t.exp & B_WB) != 13'h0) exp_stall++;
  endtask

  task automatic apply_reset();
    rst_i = 1'b1;
    apply(idle());
    #2;
    rst_i = 1'b0;
    exp_stall = 0;
    exp_bub = 0;
  endtask

  task automatic test_reset();
    stim_t t;
    logic [12:0] got, want;
    rst_i = 1'b1;
    t = idle(); t.e = IMRMOVQ; t.dm = 4'd3; t.sa = 4'd3; t.m = IMRMOVQ; t.ws = SADR;
    apply(t);
    exp_q.push_back(B_CC);
    repeat (2) @(posedge clk_i);
    #1;
    want = exp_q.pop_front(); got = obs;
    n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL reset_outputs: got %b expected %b", got, want); end
    n_checks++;
    if (dbg_state_o !== S_RUN || dbg_wait_cnt_o !== 4'd0) begin
      n_fail++; $display("FAIL reset_state: got state %0d cnt %0d expected 0 0", dbg_state_o, dbg_wait_cnt_o);
    end
    n_checks++;
    if (stall_cnt_o !== 32'd0 || bubble_cnt_o !== 32'd0) begin
      n_fail++; $display("FAIL reset_perf: got %0d/%0d expected 0/0", stall_cnt_o, bubble_cnt_o);
    end
    apply(idle());
    rst_i = 1'b0;
  endtask

  task automatic test_load_use();
    stim_t t[5];
    logic [12:0] got, want, m;
    for (int i = 0; i < 5; i++) t[i] = idle();
    t[0].e = IMRMOVQ; t[0].dm = 4'd3; t[0].sa = 4'd3; t[0].exp = B_FS | B_DS | B_EB | B_CC;
    t[2].e = IPOPQ; t[2].dm = 4'd5; t[2].sa = 4'd2; t[2].sb = 4'd5; t[2].exp = B_FS | B_DS | B_EB | B_CC;
    t[3].e = IMRMOVQ; t[3].dm = RNONE;
    t[4].e = IOPQ; t[4].dm = 4'd3; t[4].sa = 4'd3;
    for (int i = 0; i < 5; i++) begin
      drive(t[i]);
      @(negedge clk_i);
      m = msk_q.pop_front(); want = exp_q.pop_front(); got = obs & m;
      n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL load_use[%0d]: got %b expected %b", i, got, want); end
      @(posedge clk_i); #1;
    end
    n_checks++;
    if (bubble_cnt_o !== (PERF ? 32'(exp_bub) : 32'd0)) begin
      n_fail++; $display("FAIL load_use_bubble_cnt: got %0d expected %0d", bubble_cnt_o, PERF ? exp_bub : 0);
    end
  endtask

  task automatic test_branch_ret();
    stim_t t[6];
    logic [12:0] got, want, m;
    for (int i = 0; i < 6; i++) t[i] = idle();
    t[0].d = IRET; t[0].e = IJXX; t[0].cnd = 1'b0; t[0].exp = B_FS | B_DB | B_EB | B_CC;
    t[1].e = IJXX; t[1].cnd = 1'b1;
    t[2].m = IRET; t[2].ack = 1'b1; t[2].exp = B_REQ | B_FS | B_DB | B_CC;
    t[3].e = IRET; t[3].exp = B_FS | B_DB | B_CC;
    t[4].d = IRET; t[4].e = IMRMOVQ; t[4].dm = 4'd3; t[4].sa = 4'd3; t[4].exp = B_FS | B_DS | B_EB | B_CC;
    t[5].e = IJXX; t[5].cnd = 1'b0; t[5].exp = B_DB | B_EB | B_CC;
    for (int i = 0; i < 6; i++) begin
      drive(t[i]);
      @(negedge clk_i);
      m = msk_q.pop_front(); want = exp_q.pop_front(); got = obs & m;
      n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL branch_ret[%0d]: got %b expected %b", i, got, want); end
      @(posedge clk_i); #1;
    end
    n_checks++;
    if (bubble_cnt_o !== (PERF ? 32'(exp_bub) : 32'd0)) begin
      n_fail++; $display("FAIL branch_bubble_cnt: got %0d expected %0d", bubble_cnt_o, PERF ? exp_bub : 0);
    end
  endtask

  task automatic test_mem_wait();
    stim_t t[5];
    logic [12:0] got, want, m;
    for (int i = 0; i < 5; i++) t[i] = idle();
    for (int i = 0; i < 4; i++) t[i].m = IMRMOVQ;
    for (int i = 0; i < 3; i++) begin t[i].exp = WAITV; t[i].msk = WMSK; end
    t[1].d = IRET; t[1].e = IJXX; t[1].cnd = 1'b0;
    t[3].ack = 1'b1; t[3].exp = B_REQ | B_CC;
    for (int i = 0; i < 5; i++) begin
      drive(t[i]);
      @(negedge clk_i);
      m = msk_q.pop_front(); want = exp_q.pop_front(); got = obs & m;
      n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL mem_wait[%0d]: got %b expected %b", i, got, want); end
      @(posedge clk_i); #1;
    end
    n_checks++;
    if (dbg_state_o !== S_RUN || dbg_wait_cnt_o !== 4'd0) begin
      n_fail++; $display("FAIL mem_wait_state: got %0d cnt %0d expected 0 0", dbg_state_o, dbg_wait_cnt_o);
    end
    n_checks++;
    if (stall_cnt_o !== (PERF ? 32'(exp_stall) : 32'd0)) begin
      n_fail++; $display("FAIL mem_wait_stall_cnt: got %0d expected %0d", stall_cnt_o, PERF ? exp_stall : 0);
    end
  endtask

  task automatic test_ack_boundary();
    stim_t t[2];
    logic [12:0] got, want, m;
    t[0] = idle(); t[0].m = IRMMOVQ; t[0].ack = 1'b1; t[0].exp = B_REQ | B_CC;
    t[1] = idle(); t[1].m = IRMMOVQ; t[1].ms = SADR; t[1].mso = SADR; t[1].exp = B_MB;
    for (int i = 0; i < 2; i++) begin
      drive(t[i]);
      @(negedge clk_i);
      m = msk_q.pop_front(); want = exp_q.pop_front(); got = obs & m;
      n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL ack_boundary[%0d]: got %b expected %b", i, got, want); end
      @(posedge clk_i); #1;
    end
    n_checks++;
    if (dbg_state_o !== S_RUN) begin n_fail++; $display("FAIL ack_state: got %0d expected %0d", dbg_state_o, S_RUN); end
  endtask

  task automatic test_reset_mid_wait();
    stim_t t;
    logic [12:0] got, want, m;
    for (int i = 0; i < 7; i++) begin
      t = idle(); t.m = IMRMOVQ; t.exp = WAITV; t.msk = WMSK;
      drive(t);
      @(negedge clk_i);
      m = msk_q.pop_front(); want = exp_q.pop_front(); got = obs & m;
      n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL mid_wait[%0d]: got %b expected %b", i, got, want); end
      @(posedge clk_i); #1;
    end
    n_checks++;
    if (dbg_state_o !== S_WAIT || dbg_wait_cnt_o !== 4'd7) begin
      n_fail++; $display("FAIL mid_wait_state: got %0d cnt %0d expected 1 7", dbg_state_o, dbg_wait_cnt_o);
    end
    rst_i = 1'b1;
    exp_stall = 0; exp_bub = 0;
    exp_q.push_back(B_CC);
    #2;
    want = exp_q.pop_front(); got = obs;
    n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL async_reset_outputs: got %b expected %b", got, want); end
    n_checks++;
    if (dbg_state_o !== S_RUN || dbg_wait_cnt_o !== 4'd0 || stall_cnt_o !== 32'd0) begin
      n_fail++; $display("FAIL async_reset_state: got %0d cnt %0d stalls %0d expected 0 0 0", dbg_state_o, dbg_wait_cnt_o, stall_cnt_o);
    end
    t = idle();
    apply(t);
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    drive(t);
    @(negedge clk_i);
    m = msk_q.pop_front(); want = exp_q.pop_front(); got = obs & m;
    n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL after_reset_no_req: got %b expected %b", got, want); end
    @(posedge clk_i); #1;
  endtask

  task automatic test_exception_halt();
    stim_t t[4];
    logic [12:0] got, want, m;
    for (int i = 0; i < 4; i++) t[i] = idle();
    t[0].mso = SADR; t[0].exp = B_MB;
    t[1].ws = SADR; t[1].exp = B_WS | B_MB;
    t[2].ws = SADR; t[2].m = IMRMOVQ; t[2].e = IMRMOVQ; t[2].dm = 4'd3; t[2].sa = 4'd3; t[2].exp = HALTV;
    t[3].m = IMRMOVQ; t[3].ack = 1'b1; t[3].e = IJXX; t[3].cnd = 1'b0; t[3].exp = HALTV;
    for (int i = 0; i < 4; i++) begin
      drive(t[i]);
      @(negedge clk_i);
      m = msk_q.pop_front(); want = exp_q.pop_front(); got = obs & m;
      n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL exception_halt[%0d]: got %b expected %b", i, got, want); end
      @(posedge clk_i); #1;
    end
    n_checks++;
    if (dbg_state_o !== S_HALT) begin n_fail++; $display("FAIL exception_state: got %0d expected %0d", dbg_state_o, S_HALT); end
    apply_reset();
  endtask

  task automatic test_halt_priority();
    stim_t t[2];
    logic [12:0] got, want, m;
    t[0] = idle(); t[0].ws = SINS; t[0].m = IMRMOVQ; t[0].exp = WAITV; t[0].msk = WMSK;
    t[1] = idle(); t[1].m = IMRMOVQ; t[1].exp = HALTV;
    for (int i = 0; i < 2; i++) begin
      drive(t[i]);
      @(negedge clk_i);
      m = msk_q.pop_front(); want = exp_q.pop_front(); got = obs & m;
      n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL halt_priority[%0d]: got %b expected %b", i, got, want); end
      @(posedge clk_i); #1;
    end
    apply_reset();
  endtask

  task automatic test_timeout();
    stim_t t;
    logic [12:0] got, want, m;
    for (int i = 0; i < 18; i++) begin
      t = idle(); t.m = IMRMOVQ;
      if (i < 15) begin t.exp = WAITV; t.msk = WMSK; end
      else t.exp = HALTV | B_ERR;
      drive(t);
      @(negedge clk_i);
      m = msk_q.pop_front(); want = exp_q.pop_front(); got = obs & m;
      n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL timeout[%0d]: got %b expected %b", i, got, want); end
      @(posedge clk_i); #1;
    end
    n_checks++;
    if (dbg_state_o !== S_HALT) begin n_fail++; $display("FAIL timeout_state: got %0d expected %0d", dbg_state_o, S_HALT); end
    n_checks++;
    if (stall_cnt_o !== (PERF ? 32'(exp_stall) : 32'd0)) begin
      n_fail++; $display("FAIL timeout_stall_cnt: got %0d expected %0d", stall_cnt_o, PERF ? exp_stall : 0);
    end
  endtask

  // Test sequence and final report.
  initial begin
    test_reset();
    test_load_use();
    test_branch_ret();
    test_mem_wait();
    test_ack_boundary();
    test_reset_mid_wait();
    test_exception_halt();
    test_halt_priority();
    test_timeout();
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Pipeline control unit for the five-stage Y86 core.
- Each cycle it decides, from the instructions now in D, E, M and W, which of the F/D/E/M/W pipeline registers stall, take a bubble or load normally.
- It also sequences the data-memory handshake for the M stage, including wait-state stalls and a timeout.
- Holds a small FSM (RUN / MEM_WAIT / HALTED) and a wait counter. Its outputs drive the bubble/stall inputs of f_reg, dec_reg, exe_reg, mem_reg and wb_reg.

Parameters:
- WAIT_MAX, 15: maximum consecutive cycles without dmem_ack_i before timeout.
- CNT_W, 4: wait-counter width. Must satisfy 2^CNT_W > WAIT_MAX.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- D_icode_i  in  `NIBBLE  icode in D stage
- d_srcA_i  in  `NIBBLE  decode source A
- d_srcB_i  in  `NIBBLE  decode source B
- E_icode_i  in  `NIBBLE  icode in E stage
- E_dstM_i  in  `NIBBLE  E-stage memory destination register
- e_Cnd_i  in  1  branch condition computed in E
- M_icode_i  in  `NIBBLE  icode in M stage
- M_stat_i  in  `NIBBLE  status entering M
- m_stat_i  in  `NIBBLE  status leaving M
- W_stat_i  in  `NIBBLE  status in W
- dmem_ack_i  in  1  data memory completed the current access
- dmem_req_o  out  1  M-stage memory access pending
- F_stall_o, D_stall_o, E_stall_o, M_stall_o, W_stall_o  out  1 each  hold register
- D_bubble_o, E_bubble_o, M_bubble_o, W_bubble_o  out  1 each  insert bubble
- cc_en_o  out  1  condition-code update enable
- halted_o  out  1  core halted
- err_o  out  1  sticky memory-timeout error
- stall_cnt_o  out  32  memory-wait stall cycles (optional feature)
- bubble_cnt_o  out  32  hazard bubble events (optional feature)

Behaviour:
- Reset (async, rst_i=1): state=RUN, wait_cnt=0, err_o=0. Perf counters=0.
- While rst_i=1, all stall/bubble/req outputs are 0 and cc_en_o=1.
- Control outputs are combinational from the current state and inputs. State and counters update on posedge clk_i.
- mem_op: M_icode in {IRMMOVQ, IMRMOVQ, ICALL, IRET, IPUSHQ, IPOPQ}.
- mem_pending = mem_op && M_stat_i==SAOK && state!=HALTED.
- dmem_req_o = mem_pending.
- mem_wait = mem_pending && !dmem_ack_i.
- Hazard terms (RUN or MEM_WAIT, evaluated only when mem_wait=0):
  - load_use = E_icode in {IMRMOVQ, IPOPQ} && E_dstM!=RNONE && E_dstM in {d_srcA, d_srcB}.
  - ret_hz = IRET in {D_icode, E_icode, M_icode}.
  - mispred = E_icode==IJXX && !e_Cnd.
  - exc = m_stat or W_stat in {SADR, SINS, SHLT}.
- Output equations when mem_wait=0:
  - F_stall = load_use | ret_hz.
  - D_stall = load_use.
  - D_bubble = mispred | (ret_hz & !load_use).
  - E_bubble = mispred | load_use.
  - M_bubble = exc.
  - cc_en_o = !exc.
  - W_stall = W_stat!=SAOK.
- When mem_wait=1:
  - F/D/E/M stall=1 and W_bubble=1. All other bubbles=0.
  - Memory wait overrides every hazard term.
- RUN state:
  - mem_wait=1 → MEM_WAIT, wait_cnt=1.
  - W_stat_i!=SAOK → HALTED.
- MEM_WAIT state:
  - dmem_ack_i=1 → RUN, wait_cnt=0. Stalls are released in the ack cycle.
  - Otherwise wait_cnt++.
  - wait_cnt==WAIT_MAX with no ack → HALTED, err_o=1.
- HALTED state:
  - F/D/E/M/W stall=1, all bubbles 0, dmem_req_o=0, cc_en_o=0, halted_o=1.
  - Exits only on reset.
- If W_stat!=SAOK and mem_wait are both true in RUN, HALTED wins.
- Reset asserted mid-MEM_WAIT aborts the wait; no req is asserted after release until M again holds a mem_op.

Optional Feature:
- Macro PIPE_CTRL_PERF_EN.
- Defined:
  - stall_cnt_o increments each cycle with mem_wait=1.
  - bubble_cnt_o increments each cycle with (load_use | mispred) while not in mem_wait.
  - Both counters saturate at 0xFFFF_FFFF and reset to 0.
- Undefined: both ports are tied to 0 and no counter flops are built.

Test Plan:
- E_icode=IMRMOVQ, E_dstM=3, d_srcA=3, no mem op in M → F_stall=1, D_stall=1, E_bubble=1, D_bubble=0 for exactly one cycle.
- E_icode=IJXX, e_Cnd=0, D_icode=IRET → D_bubble=1, E_bubble=1, F_stall=1.
- M_icode=IMRMOVQ, M_stat=SAOK, ack low 3 cycles then high → dmem_req_o=1 for 4 cycles; F–M stall and W_bubble for 3 cycles; state returns to RUN; stall_cnt_o=3 with PIPE_CTRL_PERF_EN.
- Same access with ack never asserted, WAIT_MAX=15 → HALTED after 15 wait cycles; err_o=1; halted_o=1; dmem_req_o=0 thereafter.
- m_stat=SADR → M_bubble=1, cc_en_o=0. Next cycle W_stat=SADR → W_stall=1, then HALTED with all stalls=1.
- rst_i pulsed while in MEM_WAIT with wait_cnt=7 → state=RUN, wait_cnt=0 and all outputs 0 asynchronously; err_o stays 0.
